// File: rtl/conv_sequencer.sv
// Sequencer for a 2x2-kernel / 4x4-IFM convolution: serial load, 3x3 window sweep, registered result stream.
// Optional CONV_LAST_EN adds out_last marking the final (p=8) result of each frame.
module conv_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] dp_ifm0,
  output logic [3:0] dp_ifm1,
  output logic [3:0] dp_ifm2,
  output logic [3:0] dp_ifm3,
  output logic [3:0] dp_inw0,
  output logic [3:0] dp_inw1,
  output logic [3:0] dp_inw2,
  output logic [3:0] dp_inw3,
  input  logic [9:0] dp_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_data
`ifdef CONV_LAST_EN
  ,
  output logic       out_last
`endif
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  p_q, p_d;
  logic [3:0]  w_q [4];
  logic [3:0]  w_d [4];
  logic [3:0]  pix_q [16];
  logic [3:0]  pix_d [16];
  logic        out_valid_q, out_valid_d;
  logic [9:0]  out_data_q, out_data_d;
  logic        last_q, last_d;
  logic [3:0]  win_base;
  logic [3:0]  pix_idx;

  // Raster index of the window's top-left pixel for position p (r = p/3, c = p%3).
  always_comb begin
    win_base = 4'd0;
    case (p_q)
      4'd0:    win_base = 4'd0;
      4'd1:    win_base = 4'd1;
      4'd2:    win_base = 4'd2;
      4'd3:    win_base = 4'd4;
      4'd4:    win_base = 4'd5;
      4'd5:    win_base = 4'd6;
      4'd6:    win_base = 4'd8;
      4'd7:    win_base = 4'd9;
      4'd8:    win_base = 4'd10;
      default: win_base = 4'd0;
    endcase
  end

  assign dp_ifm0   = pix_q[win_base];
  assign dp_ifm1   = pix_q[win_base + 4'd1];
  assign dp_ifm2   = pix_q[win_base + 4'd4];
  assign dp_ifm3   = pix_q[win_base + 4'd5];
  assign dp_inw0   = w_q[0];
  assign dp_inw1   = w_q[1];
  assign dp_inw2   = w_q[2];
  assign dp_inw3   = w_q[3];
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef CONV_LAST_EN
  assign out_last  = last_q;
`endif

  // Beats 4..19 map onto pixel slots 0..15; 4-bit wrap makes the subtraction exact.
  assign pix_idx = cnt_q[3:0] - 4'd4;

  // Next-state: load sequencing, window stepping and the output handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    w_d         = w_q;
    pix_d       = pix_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q < 5'd4) begin
            w_d[cnt_q[1:0]] = in_data;
          end else begin
            pix_d[pix_idx] = in_data;
          end
          if (cnt_q == 5'd19) begin
            cnt_d   = 5'd0;
            p_d     = 4'd0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        if (!out_valid_q || out_ready) begin
          out_data_d  = dp_result;
          out_valid_d = 1'b1;
          if (p_q == 4'd8) begin
            last_d  = 1'b1;
            state_d = S_DRAIN;
          end else begin
            last_d = 1'b0;
            p_d    = p_q + 4'd1;
          end
        end else begin
          p_d = p_q;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          last_d      = 1'b0;
          cnt_d       = 5'd0;
          state_d     = S_LOAD;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      cnt_q       <= 5'd0;
      p_q         <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 10'd0;
      last_q      <= 1'b0;
      for (int i = 0; i < 4; i++) w_q[i] <= 4'd0;
      for (int i = 0; i < 16; i++) pix_q[i] <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
      w_q         <= w_d;
      pix_q       <= pix_d;
    end
  end

`ifndef CONV_LAST_EN
  logic unused_last;
  assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: directed and randomized frames against a window-sum model.
module tb_conv_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] dp_ifm0, dp_ifm1, dp_ifm2, dp_ifm3;
  logic [3:0] dp_inw0, dp_inw1, dp_inw2, dp_inw3;
  logic [9:0] dp_result;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
`ifdef CONV_LAST_EN
  logic       out_last;
`endif

  conv_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dp_ifm0(dp_ifm0), .dp_ifm1(dp_ifm1), .dp_ifm2(dp_ifm2), .dp_ifm3(dp_ifm3),
    .dp_inw0(dp_inw0), .dp_inw1(dp_inw1), .dp_inw2(dp_inw2), .dp_inw3(dp_inw3),
    .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef CONV_LAST_EN
    , .out_last(out_last)
`endif
  );

  always #5 clk = ~clk;

  // External MAC datapath stand-in
  assign dp_result = 10'(dp_ifm0) * 10'(dp_inw0) + 10'(dp_ifm1) * 10'(dp_inw1)
                   + 10'(dp_ifm2) * 10'(dp_inw2) + 10'(dp_ifm3) * 10'(dp_inw3);

  int checks = 0;
  int errors = 0;

  logic [3:0] fw [4];
  logic [3:0] fp [16];
  logic [9:0] res [16];
  int nres, first_k, ready_k, unstable, last_bad, load_to;

  function automatic int model(input int p);
    int r, c, s;
    r = p / 3;
    c = p % 3;
    s = int'(fw[0]) * int'(fp[r*4 + c])     + int'(fw[1]) * int'(fp[r*4 + c + 1])
      + int'(fw[2]) * int'(fp[(r+1)*4 + c]) + int'(fw[3]) * int'(fp[(r+1)*4 + c + 1]);
    return s;
  endfunction

  // Called at a negedge; returns at the negedge just after the edge accepting beat 19.
  task automatic drive_frame(input int gap_mode);
    int i = 0;
    int cyc = 0;
    load_to = 0;
    while (i < 20 && cyc < 400) begin
      if ((gap_mode == 1 && cyc % 2 == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = (i < 4) ? fw[i] : fp[i - 4];
        if (in_ready) i++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (i < 20) load_to = 1;
  endtask

  // Drives out_ready and records transfers; k counts negedges after the final load beat.
  task automatic collect(input int stall_mode, input int stop_after);
    int k = 0;
    int stalls = 0;
    logic prev_hold = 1'b0;
    logic [9:0] prev_data = 10'd0;
    nres = 0; first_k = -1; ready_k = -1; unstable = 0; last_bad = 0;
    for (int i = 0; i < 16; i++) res[i] = 'x;
    while (k < 300) begin
      if (out_valid && first_k < 0) first_k = k;
      if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data)) unstable++;
`ifdef CONV_LAST_EN
      if (out_last !== (out_valid && nres == 8)) last_bad++;
`endif
      if (nres >= 9 && in_ready) begin
        ready_k = k;
        break;
      end
      case (stall_mode)
        1:       out_ready = (k % 3 == 1);
        2:       out_ready = 1'($urandom_range(0, 1));
        3: begin
          out_ready = !(out_valid && nres == 8 && stalls < 3);
          if (!out_ready) stalls++;
        end
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready) begin
        if (nres < 16) res[nres] = out_data;
        nres++;
        if (nres == stop_after) break;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got in_ready=%b out_valid=%b out_data=%0d exp 1 0 0", in_ready, out_valid, out_data);
    end
    checks++;
    if ({dp_ifm0, dp_ifm1, dp_ifm2, dp_ifm3, dp_inw0, dp_inw1, dp_inw2, dp_inw3} !== 32'd0) begin
      errors++;
      $display("FAIL reset_dp got %h exp 0", {dp_ifm0, dp_ifm1, dp_ifm2, dp_ifm3, dp_inw0, dp_inw1, dp_inw2, dp_inw3});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) fw[i] = 4'd1;
    for (int i = 0; i < 16; i++) fp[i] = 4'(i);
    drive_frame(0);
    collect(0, 99);
    checks++;
    if (model(0) != 10 || model(8) != 50) begin
      errors++; $display("FAIL basic_model got %0d %0d exp 10 50", model(0), model(8));
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (res[i] !== 10'(model(i))) begin
        errors++; $display("FAIL basic_res[%0d] got %0d exp %0d", i, res[i], model(i));
      end
    end
    checks++;
    if (load_to != 0 || nres != 9 || first_k != 1 || ready_k != 10) begin
      errors++;
      $display("FAIL basic_timing got to=%0d n=%0d first=%0d ready=%0d exp 0 9 1 10", load_to, nres, first_k, ready_k);
    end
    checks++;
    if (last_bad != 0) begin errors++; $display("FAIL basic_last got %0d bad cycles exp 0", last_bad); end
  endtask

  task automatic test_max;
    for (int i = 0; i < 4; i++) fw[i] = 4'd15;
    for (int i = 0; i < 16; i++) fp[i] = 4'd15;
    drive_frame(0);
    collect(0, 99);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (res[i] !== 10'd900) begin errors++; $display("FAIL max_res[%0d] got %0d exp 900", i, res[i]); end
    end
    checks++;
    if (nres != 9 || ready_k != 10) begin errors++; $display("FAIL max_count got n=%0d ready=%0d exp 9 10", nres, ready_k); end
  endtask

  task automatic test_gap_stall;
    for (int i = 0; i < 4; i++) fw[i] = 4'(i + 1);
    for (int i = 0; i < 16; i++) fp[i] = 4'(i);
    drive_frame(1);
    collect(1, 99);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (res[i] !== 10'(model(i))) begin errors++; $display("FAIL gap_res[%0d] got %0d exp %0d", i, res[i], model(i)); end
    end
    checks++;
    if (load_to != 0 || nres != 9 || unstable != 0 || last_bad != 0) begin
      errors++; $display("FAIL gap_stream got to=%0d n=%0d unstable=%0d lastbad=%0d exp 0 9 0 0", load_to, nres, unstable, last_bad);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) fw[i] = 4'd1;
    for (int i = 0; i < 16; i++) fp[i] = 4'(i);
    drive_frame(0);
    collect(0, 99);
    fw[0] = 4'd0; fw[1] = 4'd0; fw[2] = 4'd0; fw[3] = 4'd1;
    for (int i = 0; i < 16; i++) fp[i] = 4'(15 - i);
    drive_frame(0);
    collect(0, 99);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (res[i] !== 10'(model(i))) begin errors++; $display("FAIL b2b_res[%0d] got %0d exp %0d", i, res[i], model(i)); end
    end
    checks++;
    if (nres != 9 || first_k != 1 || ready_k != 10) begin
      errors++; $display("FAIL b2b_timing got n=%0d first=%0d ready=%0d exp 9 1 10", nres, first_k, ready_k);
    end
  endtask

  task automatic test_reset_mid_run;
    for (int i = 0; i < 4; i++) fw[i] = 4'($urandom_range(1, 15));
    for (int i = 0; i < 16; i++) fp[i] = 4'($urandom_range(1, 15));
    drive_frame(0);
    collect(0, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== 10'(model(i))) begin errors++; $display("FAIL rst_pre_res[%0d] got %0d exp %0d", i, res[i], model(i)); end
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 10'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got out_valid=%b out_data=%0d in_ready=%b exp 0 0 1", out_valid, out_data, in_ready);
    end
    checks++;
    if ({dp_ifm0, dp_ifm1, dp_ifm2, dp_ifm3, dp_inw0, dp_inw1, dp_inw2, dp_inw3} !== 32'd0) begin
      errors++; $display("FAIL rst_mid_dp got %h exp 0", {dp_ifm0, dp_ifm1, dp_ifm2, dp_ifm3, dp_inw0, dp_inw1, dp_inw2, dp_inw3});
    end
`ifdef CONV_LAST_EN
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_mid_last got %b exp 0", out_last); end
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) fw[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) fp[i] = 4'($urandom_range(0, 15));
    drive_frame(0);
    collect(0, 99);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (res[i] !== 10'(model(i))) begin errors++; $display("FAIL rst_post_res[%0d] got %0d exp %0d", i, res[i], model(i)); end
    end
    checks++;
    if (nres != 9 || ready_k != 10) begin errors++; $display("FAIL rst_post_count got n=%0d ready=%0d exp 9 10", nres, ready_k); end
  endtask

  task automatic test_last_stall;
    for (int i = 0; i < 4; i++) fw[i] = 4'd1;
    for (int i = 0; i < 16; i++) fp[i] = 4'(i);
    drive_frame(0);
    collect(3, 99);
    checks++;
    if (res[8] !== 10'd50 || nres != 9) begin errors++; $display("FAIL last_res got %0d n=%0d exp 50 9", res[8], nres); end
    checks++;
    if (unstable != 0 || last_bad != 0 || ready_k != 13) begin
      errors++; $display("FAIL last_stall got unstable=%0d lastbad=%0d ready=%0d exp 0 0 13", unstable, last_bad, ready_k);
    end
  endtask

  task automatic test_random;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) fw[i] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) fp[i] = 4'($urandom_range(0, 15));
      drive_frame(2);
      collect(2, 99);
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (res[i] !== 10'(model(i))) begin
          errors++; $display("FAIL rand_res f%0d[%0d] got %0d exp %0d", f, i, res[i], model(i));
        end
      end
      checks++;
      if (load_to != 0 || nres != 9 || unstable != 0 || last_bad != 0 || ready_k < 10) begin
        errors++;
        $display("FAIL rand_stream f%0d got to=%0d n=%0d unstable=%0d lastbad=%0d ready=%0d", f, load_to, nres, unstable, last_bad, ready_k);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_gap_stall;
    test_back_to_back;
    test_reset_mid_run;
    test_last_stall;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
